// File: rtl/sif_bridge.sv
// X-to-W register write bridge: shadow register file with read-back,
// show-ahead forwarding FIFO to the W side, and dropped-write accounting.
module sif_bridge #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int REG_COUNT  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] xa_addr,
  input  logic [DW-1:0] xa_data_wr,
  input  logic          xa_wr_s,
  input  logic          xa_rd_s,
  output logic [DW-1:0] xa_data_rd,
  output logic          xa_rd_vld,
  output logic          xa_full,
  output logic [AW-1:0] wa_addr,
  output logic [DW-1:0] wa_data_wr,
  output logic          wa_wr_s,
  input  logic          wa_ready,
  output logic [7:0]    drop_cnt,
  output logic          ovf
);

  localparam int IW = $clog2(REG_COUNT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] REG_LIM  = (AW+1)'(REG_COUNT);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          fifo   [FIFO_DEPTH];
  logic [DW-1:0] shadow [REG_COUNT];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign idx      = xa_addr[IW-1:0];
  assign in_range = {1'b0, xa_addr} < REG_LIM;
  assign full     = count == FULL_CNT;
  assign push     = xa_wr_s && !full;
  assign drop     = xa_wr_s && full;
  assign pop      = wa_wr_s && wa_ready;

  assign wa_wr_s    = count != '0;
  assign wa_addr    = fifo[rd_ptr].addr;
  assign wa_data_wr = fifo[rd_ptr].data;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Cleared entries keep the W-side head at zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      xa_full <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{addr: xa_addr, data: xa_data_wr};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      xa_full <= count_nxt == FULL_CNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        shadow[i] <= '0;
    end else if (push && in_range) begin
      shadow[idx] <= xa_data_wr;
    end
  end

  // Read samples the shadow before this edge's write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xa_rd_vld  <= 1'b0;
      xa_data_rd <= '0;
    end else begin
      xa_rd_vld  <= xa_rd_s;
      xa_data_rd <= (xa_rd_s && in_range) ? shadow[idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: doc/sif_bridge.md
# sif_bridge

Parametrised successor to the SIF X-to-W write path. It accepts X-side register writes and reads, keeps a local shadow register file, and forwards every accepted write to the W side through a buffered, back-pressured FIFO. It sits between the X-side master (test driver or CPU port) and the W-side write consumer. It adds read-back, configurable widths and depth, overflow accounting and W-side flow control, none of which the previous generation has.

## Interface
- AW, 16, address width (≥ log2(REG_COUNT))
- DW, 16, data width
- REG_COUNT, 16, shadow registers, power of two ≥ 2
- FIFO_DEPTH, 4, forwarding FIFO entries, power of two ≥ 2

- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- xa_addr  in  AW  X-side address
- xa_data_wr  in  DW  X-side write data
- xa_wr_s  in  1  X-side write strobe, one access per cycle high
- xa_rd_s  in  1  X-side read strobe
- xa_data_rd  out  DW  read data, registered
- xa_rd_vld  out  1  xa_data_rd valid, single-cycle pulse
- xa_full  out  1  forwarding FIFO full, registered
- wa_addr  out  AW  W-side address (FIFO head)
- wa_data_wr  out  DW  W-side data (FIFO head)
- wa_wr_s  out  1  W-side valid (FIFO non-empty)
- wa_ready  in  1  W-side accept
- drop_cnt  out  8  saturating count of dropped writes
- ovf  out  1  sticky: at least one write dropped

## Operation
- Shadow index = xa_addr[log2(REG_COUNT)-1:0]; "in range" means xa_addr < REG_COUNT.
- Write (xa_wr_s=1):
  - If count < FIFO_DEPTH: push {xa_addr, xa_data_wr}. If in range, also update the shadow register.
  - If count == FIFO_DEPTH: the write is dropped entirely (no shadow update, no push), even if a pop occurs in the same cycle. ovf is set and drop_cnt increments, saturating at 255.
- Read (xa_rd_s=1): next cycle xa_rd_vld=1 and xa_data_rd = shadow[index] if in range, else 0. Reads never touch the FIFO.
- Simultaneous write and read, same cycle: the read returns the pre-write value. The write proceeds normally.
- FIFO is show-ahead. wa_addr/wa_data_wr always present the head entry and wa_wr_s = (count != 0).
  - Pop when wa_wr_s && wa_ready.
  - Push and pop in the same cycle (not full) leave count unchanged.
- While wa_wr_s=1 and wa_ready=0, wa_addr/wa_data_wr/wa_wr_s hold stable.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
- ovf and drop_cnt clear only on reset.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - Outputs: xa_data_rd=0, xa_rd_vld=0, xa_full=0, wa_wr_s=0, wa_addr=0, wa_data_wr=0, drop_cnt=0, ovf=0.
  - Internal: FIFO empty, all shadow registers 0.
- Reset asserted mid-operation discards all FIFO contents and shadow state immediately. No W-side write completes after reset assertion.
- Write to W latency: a write accepted at edge N shows wa_wr_s=1 after edge N (visible in cycle N+1) if the FIFO was empty.
- Read latency: 1 cycle.
- xa_full reflects count after the current edge. The X master must sample it before driving the next strobe; writes issued while it is high are dropped as defined above.
- Throughput: one write per cycle sustained while wa_ready=1 continuously.

## Test plan
- Reset, then write addr 0x0003 data 0xBEEF with wa_ready=1 -> wa_wr_s pulses one cycle with 0x0003/0xBEEF; read 0x0003 -> xa_rd_vld next cycle, xa_data_rd=0xBEEF.
- wa_ready=0, 6 back-to-back writes (data 1..6), FIFO_DEPTH=4 -> xa_full=1 after the 4th write; writes 5 and 6 dropped, drop_cnt=2, ovf=1. Release wa_ready -> W sees exactly data 1,2,3,4 in order. Shadow holds data 4 if all addresses are equal.
- Out-of-range write addr 0x0100 data 0x1234 -> forwarded to W unchanged; read 0x0100 -> xa_data_rd=0, shadow unchanged.
- Write and read of addr 5 in the same cycle (old value 0xAAAA, new value 0x5555) -> read returns 0xAAAA; a following read returns 0x5555.
- Toggle wa_ready every cycle over 20 random writes -> W output order and content match the input order; head stable while stalled; count wraps pointers without loss.
- Assert rst_n=0 mid-burst with 3 entries queued -> all outputs 0 asynchronously, FIFO empty after release, no further wa_wr_s.
